// File: rtl/sc130_i2c_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sc130_i2c_reg_slave : I2C slave bridging to a 16-bit-addressed register  |
// | file (2-byte pointer, burst write, sequential read). Revision: 1.0       |
// +--------------------------------------------------------------------------+
module sc130_i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h30,
  parameter int         GLITCH_LEN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        reg_wr_en,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  localparam int               CNT_W   = (GLITCH_LEN > 1) ? $clog2(GLITCH_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GLITCH_LEN - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEV      = 4'd1,
    DEV_ACK  = 4'd2,
    AH       = 4'd3,
    AH_ACK   = 4'd4,
    AL       = 4'd5,
    AL_ACK   = 4'd6,
    WDAT     = 4'd7,
    WDAT_ACK = 4'd8,
    RDAT     = 4'd9,
    MACK     = 4'd10
  } state_t;

  logic [1:0] pad_in;
  logic [1:0] filt;

  assign pad_in = {scl_in, sda_in};

  // Index 1 = SCL, index 0 = SDA; a level is accepted only after it has
  // differed from the filtered value for GLITCH_LEN consecutive samples.
  for (genvar i = 0; i < 2; i++) begin : g_filt
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;

    always_comb begin
      sync_d = {sync_q[0], pad_in[i]};
      cnt_d  = '0;
      lvl_d  = lvl_q;
      if (sync_q[1] != lvl_q) begin
        if (cnt_q == CNT_MAX) lvl_d = sync_q[1];
        else                  cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= 2'b11;
        cnt_q  <= '0;
        lvl_q  <= 1'b1;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
      end
    end

    assign filt[i] = lvl_q;
  end

  logic scl_f, sda_f;
  logic scl_p_q, sda_p_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_f     = filt[1];
  assign sda_f     = filt[0];
  assign scl_rise  = scl_f & ~scl_p_q;
  assign scl_fall  = ~scl_f & scl_p_q;
  assign start_det = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop_det  = scl_f & scl_p_q & ~sda_p_q & sda_f;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  ah_q, ah_d;
  logic        rw_q, rw_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        ld_q, ld_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [7:0]  byte_in;

  assign byte_in = {sh_q[6:0], sda_f};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    ah_d      = ah_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    ld_d      = rd_en_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;

    if (wr_en_q) ptr_d = ptr_q + 16'd1;
    // Read data arrives the clk after the request; present the MSB at once.
    if (ld_q && (state_q == RDAT)) begin
      sh_d     = reg_rdata;
      sda_oe_d = ~reg_rdata[7];
    end

    if (start_det) begin
      state_d   = DEV;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      ld_d      = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ld_d      = 1'b0;
    end else begin
      case (state_q)
        DEV, AH, AL, WDAT: begin
          if (scl_rise) begin
            sh_d      = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              case (state_q)
                DEV: begin
                  if (sh_q[6:0] == SLAVE_ADDR) begin
                    state_d = DEV_ACK;
                    rw_d    = sda_f;
                  end else begin
                    state_d   = IDLE;
                    bit_cnt_d = 4'd0;
                  end
                end
                AH: begin
                  ah_d    = byte_in;
                  state_d = AH_ACK;
                end
                AL: begin
                  ptr_d   = {ah_q, byte_in};
                  state_d = AL_ACK;
                end
                default: begin
                  wr_en_d = 1'b1;
                  wdata_d = byte_in;
                  state_d = WDAT_ACK;
                end
              endcase
            end
          end
        end

        // bit_cnt 8 = waiting for the fall that starts the ACK, 9 = ACK clocked.
        DEV_ACK, AH_ACK, AL_ACK, WDAT_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = 4'd9;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              case (state_q)
                DEV_ACK: begin
                  if (rw_q) begin
                    state_d = RDAT;
                    rd_en_d = 1'b1;
                  end else begin
                    state_d = AH;
                  end
                end
                AH_ACK:  state_d = AL;
                default: state_d = WDAT;
              endcase
            end
          end
        end

        RDAT: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = MACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end else begin
              sh_d     = {sh_q[6:0], 1'b0};
              sda_oe_d = ~sh_q[6];
            end
          end
        end

        MACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              ptr_d     = ptr_q + 16'd1;
              bit_cnt_d = 4'd9;
            end else begin
              state_d = IDLE;
            end
          end else if (scl_fall && (bit_cnt_q == 4'd9)) begin
            state_d   = RDAT;
            rd_en_d   = 1'b1;
            bit_cnt_d = 4'd0;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p_q   <= 1'b1;
      sda_p_q   <= 1'b1;
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      sh_q      <= 8'h00;
      ah_q      <= 8'h00;
      rw_q      <= 1'b0;
      ptr_q     <= 16'h0000;
      wdata_q   <= 8'h00;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      ld_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      scl_p_q   <= scl_f;
      sda_p_q   <= sda_f;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      ah_q      <= ah_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      wdata_q   <= wdata_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      ld_q      <= ld_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_wr_en = wr_en_q;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_rd_en = rd_en_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sc130_i2c_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sc130_i2c_reg_slave : directed bench for the I2C register slave.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sc130_i2c_reg_slave;

  localparam int Q = 12;

  logic        clk;
  logic        rst_n;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic        reg_wr_en;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_rd_en;
  logic [7:0]  reg_rdata;
  logic        busy;

  logic m_scl, m_sda;
  int   n_chk, n_pass;
  logic oe_seen;

  logic [15:0] wr_addr_log[$];
  logic [7:0]  wr_data_log[$];
  logic [15:0] rd_addr_log[$];

  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_oe;

  sc130_i2c_reg_slave #(.SLAVE_ADDR(7'h30), .GLITCH_LEN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .reg_wr_en (reg_wr_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_addr_log.push_back(reg_addr);
      wr_data_log.push_back(reg_wdata);
    end
    if (reg_rd_en) rd_addr_log.push_back(reg_addr);
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_addr_log.delete();
    oe_seen = 1'b0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    tick(Q);
    m_scl = 1'b1; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic s);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    s = sda_in;
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      read_bit(s);
      d[i] = s;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; reg_rdata = 8'h00;
    tick(4);
    n_chk++; if (sda_oe !== 1'b0)       $display("FAIL rst_sda_oe: got %b expected 0", sda_oe);       else n_pass++;
    n_chk++; if (reg_wr_en !== 1'b0)    $display("FAIL rst_wr_en: got %b expected 0", reg_wr_en);     else n_pass++;
    n_chk++; if (reg_rd_en !== 1'b0)    $display("FAIL rst_rd_en: got %b expected 0", reg_rd_en);     else n_pass++;
    n_chk++; if (reg_addr !== 16'h0000) $display("FAIL rst_addr: got %h expected 0000", reg_addr);    else n_pass++;
    n_chk++; if (reg_wdata !== 8'h00)   $display("FAIL rst_wdata: got %h expected 00", reg_wdata);    else n_pass++;
    n_chk++; if (busy !== 1'b0)         $display("FAIL rst_busy: got %b expected 0", busy);           else n_pass++;
    rst_n = 1'b1;
    tick(Q);
  endtask

  task automatic test_write();
    logic a;
    int   acks;
    clear_logs();
    acks = 0;
    i2c_start();
    n_chk++; if (busy !== 1'b1) $display("FAIL wr_busy_start: got %b expected 1", busy); else n_pass++;
    write_byte(8'h60, a); acks += int'(a);
    write_byte(8'h30, a); acks += int'(a);
    write_byte(8'h39, a); acks += int'(a);
    write_byte(8'h80, a); acks += int'(a);
    i2c_stop();
    n_chk++; if (acks != 4) $display("FAIL wr_acks: got %0d expected 4", acks); else n_pass++;
    n_chk++; if (wr_addr_log.size() != 1) $display("FAIL wr_strobes: got %0d expected 1", wr_addr_log.size()); else n_pass++;
    if (wr_addr_log.size() >= 1) begin
      n_chk++; if (wr_addr_log[0] !== 16'h3039) $display("FAIL wr_addr: got %h expected 3039", wr_addr_log[0]); else n_pass++;
      n_chk++; if (wr_data_log[0] !== 8'h80)    $display("FAIL wr_data: got %h expected 80", wr_data_log[0]);   else n_pass++;
    end
    n_chk++; if (reg_addr !== 16'h303A) $display("FAIL wr_ptr_inc: got %h expected 303a", reg_addr); else n_pass++;
    n_chk++; if (busy !== 1'b0)         $display("FAIL wr_busy_stop: got %b expected 0", busy);      else n_pass++;
  endtask

  task automatic test_burst_wrap();
    logic a;
    int   acks;
    clear_logs();
    acks = 0;
    i2c_start();
    write_byte(8'h60, a); acks += int'(a);
    write_byte(8'hFF, a); acks += int'(a);
    write_byte(8'hFF, a); acks += int'(a);
    write_byte(8'h11, a); acks += int'(a);
    write_byte(8'h22, a); acks += int'(a);
    i2c_stop();
    n_chk++; if (acks != 5) $display("FAIL burst_acks: got %0d expected 5", acks); else n_pass++;
    n_chk++; if (wr_addr_log.size() != 2) $display("FAIL burst_strobes: got %0d expected 2", wr_addr_log.size()); else n_pass++;
    if (wr_addr_log.size() >= 2) begin
      n_chk++; if (wr_addr_log[0] !== 16'hFFFF || wr_data_log[0] !== 8'h11)
        $display("FAIL burst_first: got %h/%h expected ffff/11", wr_addr_log[0], wr_data_log[0]); else n_pass++;
      n_chk++; if (wr_addr_log[1] !== 16'h0000 || wr_data_log[1] !== 8'h22)
        $display("FAIL burst_wrap: got %h/%h expected 0000/22", wr_addr_log[1], wr_data_log[1]); else n_pass++;
    end
    n_chk++; if (reg_addr !== 16'h0001) $display("FAIL burst_ptr: got %h expected 0001", reg_addr); else n_pass++;
  endtask

  task automatic test_bad_addr();
    logic a1, a2;
    clear_logs();
    i2c_start();
    write_byte(8'h62, a1);
    write_byte(8'h60, a2);
    i2c_stop();
    n_chk++; if (a1 !== 1'b0)      $display("FAIL bad_ack: got %b expected 0", a1);          else n_pass++;
    n_chk++; if (a2 !== 1'b0)      $display("FAIL bad_idle_ack: got %b expected 0", a2);     else n_pass++;
    n_chk++; if (oe_seen !== 1'b0) $display("FAIL bad_sda_oe: got %b expected 0", oe_seen); else n_pass++;
    n_chk++; if (wr_addr_log.size() != 0) $display("FAIL bad_strobes: got %0d expected 0", wr_addr_log.size()); else n_pass++;
    n_chk++; if (reg_addr !== 16'h0001) $display("FAIL bad_ptr: got %h expected 0001", reg_addr); else n_pass++;
  endtask

  task automatic test_read();
    logic       a;
    int         acks;
    logic [7:0] d;
    clear_logs();
    acks = 0;
    reg_rdata = 8'h2C;
    i2c_start();
    write_byte(8'h60, a); acks += int'(a);
    write_byte(8'h31, a); acks += int'(a);
    write_byte(8'h07, a); acks += int'(a);
    i2c_start();
    write_byte(8'h61, a); acks += int'(a);
    read_byte(d);
    write_bit(1'b1);
    i2c_stop();
    n_chk++; if (acks != 4)   $display("FAIL rd_acks: got %0d expected 4", acks); else n_pass++;
    n_chk++; if (d !== 8'h2C) $display("FAIL rd_data: got %h expected 2c", d);   else n_pass++;
    n_chk++; if (rd_addr_log.size() != 1) $display("FAIL rd_strobes: got %0d expected 1", rd_addr_log.size()); else n_pass++;
    if (rd_addr_log.size() >= 1) begin
      n_chk++; if (rd_addr_log[0] !== 16'h3107) $display("FAIL rd_addr: got %h expected 3107", rd_addr_log[0]); else n_pass++;
    end
    n_chk++; if (wr_addr_log.size() != 0) $display("FAIL rd_no_write: got %0d expected 0", wr_addr_log.size()); else n_pass++;
    n_chk++; if (reg_addr !== 16'h3107)   $display("FAIL rd_ptr: got %h expected 3107", reg_addr); else n_pass++;
  endtask

  task automatic test_read_burst();
    logic       a;
    logic [7:0] d0, d1;
    clear_logs();
    reg_rdata = 8'h2C;
    i2c_start();
    write_byte(8'h61, a);
    read_byte(d0);
    reg_rdata = 8'hA5;
    write_bit(1'b0);
    read_byte(d1);
    write_bit(1'b1);
    i2c_stop();
    n_chk++; if (a !== 1'b1)   $display("FAIL rdb_ack: got %b expected 1", a);    else n_pass++;
    n_chk++; if (d0 !== 8'h2C) $display("FAIL rdb_d0: got %h expected 2c", d0);   else n_pass++;
    n_chk++; if (d1 !== 8'hA5) $display("FAIL rdb_d1: got %h expected a5", d1);   else n_pass++;
    n_chk++; if (rd_addr_log.size() != 2) $display("FAIL rdb_strobes: got %0d expected 2", rd_addr_log.size()); else n_pass++;
    if (rd_addr_log.size() >= 2) begin
      n_chk++; if (rd_addr_log[1] !== 16'h3108) $display("FAIL rdb_addr2: got %h expected 3108", rd_addr_log[1]); else n_pass++;
    end
    n_chk++; if (reg_addr !== 16'h3108) $display("FAIL rdb_ptr: got %h expected 3108", reg_addr); else n_pass++;
  endtask

  task automatic test_stop_partial();
    logic a;
    clear_logs();
    i2c_start();
    write_byte(8'h60, a);
    write_byte(8'h12, a);
    write_byte(8'h34, a);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    n_chk++; if (wr_addr_log.size() != 0) $display("FAIL part_strobes: got %0d expected 0", wr_addr_log.size()); else n_pass++;
    n_chk++; if (reg_addr !== 16'h1234)   $display("FAIL part_ptr: got %h expected 1234", reg_addr); else n_pass++;
    n_chk++; if (busy !== 1'b0)           $display("FAIL part_busy: got %b expected 0", busy);      else n_pass++;
  endtask

  task automatic test_glitch();
    tick(Q);
    m_sda = 1'b0; tick(1);
    m_sda = 1'b1; tick(3 * Q);
    n_chk++; if (busy !== 1'b0) $display("FAIL glitch_no_start: got %b expected 0", busy); else n_pass++;
    i2c_start();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(1);
    m_sda = 1'b0; tick(3 * Q);
    n_chk++; if (busy !== 1'b1) $display("FAIL glitch_no_stop: got %b expected 1", busy); else n_pass++;
    m_scl = 1'b0; tick(Q);
    i2c_stop();
    n_chk++; if (busy !== 1'b0) $display("FAIL glitch_real_stop: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic a;
    clear_logs();
    i2c_start();
    write_byte(8'h60, a);
    write_byte(8'h40, a);
    write_byte(8'h00, a);
    for (int i = 7; i >= 0; i--) write_bit(8'hAB >> i);
    n_chk++; if (sda_oe !== 1'b1) $display("FAIL rm_ack_drive: got %b expected 1", sda_oe); else n_pass++;
    n_chk++; if (wr_addr_log.size() != 1) $display("FAIL rm_strobe: got %0d expected 1", wr_addr_log.size()); else n_pass++;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (sda_oe !== 1'b0)       $display("FAIL rm_sda_oe: got %b expected 0", sda_oe);     else n_pass++;
    n_chk++; if (reg_addr !== 16'h0000) $display("FAIL rm_addr: got %h expected 0000", reg_addr);  else n_pass++;
    n_chk++; if (reg_wdata !== 8'h00)   $display("FAIL rm_wdata: got %h expected 00", reg_wdata);  else n_pass++;
    n_chk++; if (busy !== 1'b0)         $display("FAIL rm_busy: got %b expected 0", busy);         else n_pass++;
    n_chk++; if (reg_wr_en !== 1'b0 || reg_rd_en !== 1'b0)
      $display("FAIL rm_strobes: got %b%b expected 00", reg_wr_en, reg_rd_en); else n_pass++;
    tick(3);
    rst_n = 1'b1;
    tick(Q);
    write_byte(8'h60, a);
    n_chk++; if (a !== 1'b0) $display("FAIL rm_no_start_ack: got %b expected 0", a); else n_pass++;
    i2c_start();
    write_byte(8'h60, a);
    n_chk++; if (a !== 1'b1) $display("FAIL rm_fresh_ack: got %b expected 1", a); else n_pass++;
    i2c_stop();
    n_chk++; if (busy !== 1'b0) $display("FAIL rm_busy_end: got %b expected 0", busy); else n_pass++;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    oe_seen = 1'b0;
    rst_n   = 1'b0;
    m_scl   = 1'b1;
    m_sda   = 1'b1;
    reg_rdata = 8'h00;
    test_reset();
    test_write();
    test_burst_wrap();
    test_bad_addr();
    test_read();
    test_read_burst();
    test_stop_partial();
    test_glitch();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sc130_i2c_reg_slave.md
SC130_I2C_REG_SLAVE -- requirements
Module: sc130_i2c_reg_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h30, the 7-bit I2C device address the block answers to.
REQ-002 SHALL have parameter GLITCH_LEN, default 3, the number of consecutive equal synchronized samples needed to accept an SCL/SDA level change.
REQ-003 clk  input  1  system clock; at least 16x the SCL rate.
REQ-004 rst_n  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-005 scl_in  input  1  I2C SCL from the pad, asynchronous.
REQ-006 sda_in  input  1  I2C SDA from the pad, asynchronous.
REQ-007 sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain).
REQ-008 reg_wr_en  output  1  one-clk write strobe to the sensor register file.
REQ-009 reg_addr  output  16  current register pointer.
REQ-010 reg_wdata  output  8  write data; valid while reg_wr_en=1.
REQ-011 reg_rd_en  output  1  one-clk read request at reg_addr.
REQ-012 reg_rdata  input  8  read data; valid the clk after reg_rd_en.
REQ-013 busy  output  1  1 from START to STOP.

Function
REQ-014 scl_in/sda_in SHALL pass a 2-FF synchronizer, then a GLITCH_LEN-sample filter; all logic uses the filtered levels.
REQ-015 START SHALL be detected when SDA falls while SCL=1; STOP when SDA rises while SCL=1.
REQ-016 Data bits SHALL be sampled on filtered SCL rise, MSB first; sda_oe SHALL change only on the clk after a filtered SCL fall.
REQ-017 States: IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WDAT, WDAT_ACK, RDAT, MACK.
REQ-018 START (including repeated START) from any state SHALL go to DEV, with the bit counter cleared and sda_oe=0; STOP from any state SHALL go to IDLE with sda_oe=0.
REQ-019 DEV: after 8 bits, if bits[7:1]==SLAVE_ADDR then go to DEV_ACK; otherwise go to IDLE and drive no ACK.
REQ-020 ACK states SHALL hold sda_oe=1 from the SCL fall after bit 8 to the SCL fall after the 9th clock.
REQ-021 After DEV_ACK: R/W=0 goes to AH, then AL (pointer = {AH,AL}, loaded at AL end), then WDAT; R/W=1 goes to RDAT using the current pointer.
REQ-022 WDAT: on the clk after the 8th bit is sampled, reg_wr_en=1 for exactly one clk with reg_wdata=byte and reg_addr=pointer; then ACK; the pointer increments after the strobe; further bytes repeat this (burst write).
REQ-023 RDAT entry and each master ACK: reg_rd_en=1 for one clk on the SCL fall ending the ACK bit; the shifter loads reg_rdata on the next clk; for each bit, sda_oe = ~bit, driven from that SCL fall.
REQ-024 MACK: sda_oe=0; if master SDA=0 on SCL rise, increment the pointer and return to RDAT; if SDA=1 (NACK), stay idle until START or STOP.
REQ-025 The pointer SHALL be 16-bit and wrap 16'hFFFF to 16'h0000; it is retained across transactions.
REQ-026 A partial byte aborted by START or STOP SHALL produce no strobe and no pointer change.
REQ-027 busy SHALL set on the clk START is detected and clear on the clk STOP is detected.

Reset
REQ-028 While rst_n=0: state=IDLE, sda_oe=0, reg_wr_en=0, reg_rd_en=0, reg_addr=16'h0000, reg_wdata=8'h00, busy=0, synchronizers and filters=1 (bus idle).
REQ-029 Reset asserted mid-transfer SHALL release SDA asynchronously; after release the block waits for a fresh START.

Verification
REQ-030 Write 0x60, 0x30, 0x39, 0x80, STOP -> 4 ACKs; one reg_wr_en with reg_addr=0x3039, reg_wdata=0x80.
REQ-031 Burst write at pointer 0xFFFF with data 0x11, 0x22 -> strobes at 0xFFFF/0x11 then 0x0000/0x22.
REQ-032 Device byte 0x62 -> no ACK (sda_oe stays 0), no strobes, state IDLE until the next START.
REQ-033 Write 0x60, 0x31, 0x07, Sr, 0x61, reg_rdata=0x2C, master NACK, STOP -> SDA bits 0,0,1,0,1,1,0,0; reg_rd_en once at 0x3107; reg_addr ends at 0x3107.
REQ-034 STOP after 4 bits of a data byte -> no reg_wr_en, pointer unchanged, busy=0.
REQ-035 rst_n low during WDAT_ACK -> sda_oe=0 within the same clk; all outputs at reset values.
REQ-036 A 1-clk SDA glitch while SCL=1 with GLITCH_LEN=3 -> no START or STOP detected.
